// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/response and decode-side handshake bundle
// FETCH_MISALIGN_CHK_EN adds the id_misaligned flag toward decode
interface instr_fetch_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            id_misaligned;
  modport master (output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_misaligned,
                  input imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready);
  modport slave (input imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_misaligned,
                 output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready);
`else
  modport master (output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
                  input imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready);
  modport slave (input imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
                 output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready);
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: in-order fetch queue pairing memory responses with their PCs for decode
// FETCH_MISALIGN_CHK_EN: issue addresses as-is and flag misaligned PCs on id_misaligned
module instr_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_current,
  output logic            pc_en,
  input  logic            flush,
  instr_fetch_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr;
  logic [PW:0] occ, in_flight;
  logic [CW-1:0] discard_cnt;
  logic [PW+1:0] discard_sum;
  logic [DEPTH-1:0] filled;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic req_fire, rsp_fill, rsp_drop, id_fire;
  assign bus.imem_req_valid = rst_n && !flush && occ < FULL;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign pc_en = rst_n && (req_fire || flush);
  assign rsp_fill = bus.imem_rsp_valid && discard_cnt == '0;
  assign rsp_drop = bus.imem_rsp_valid && discard_cnt != '0;
  assign bus.id_valid = filled[rd_ptr] && !flush;
  assign bus.id_pc = pc_q[rd_ptr];
  assign bus.id_instr = instr_q[rd_ptr];
  assign id_fire = bus.id_valid && bus.id_ready;
  // in-flight fetches become discards; a response landing this cycle retires one of them
  assign discard_sum = (PW+2)'(in_flight) + (PW+2)'(discard_cnt) - (PW+2)'(bus.imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHK_EN
  logic [DEPTH-1:0] mis_q;
  assign bus.imem_req_addr = rst_n ? pc_current : '0;
  assign bus.id_misaligned = mis_q[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mis_q <= '0;
    else if (req_fire) mis_q[alloc_ptr] <= pc_current[1:0] != 2'b00;
`else
  assign bus.imem_req_addr = rst_n ? {pc_current[XLEN-1:2], 2'b00} : '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      in_flight <= '0;
      discard_cnt <= '0;
      filled <= '0;
      pc_q <= '{default: '0};
      instr_q <= '{default: '0};
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      in_flight <= '0;
      filled <= '0;
      discard_cnt <= CW'(discard_sum);
    end else begin
      if (req_fire) begin
        pc_q[alloc_ptr] <= pc_current;
        filled[alloc_ptr] <= 1'b0;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (rsp_fill) begin
        instr_q[fill_ptr] <= bus.imem_rsp_data;
        filled[fill_ptr] <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
      if (rsp_drop) discard_cnt <= discard_cnt - CW'(1);
      if (id_fire) begin
        filled[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ <= occ + (PW+1)'(req_fire) - (PW+1)'(id_fire);
      in_flight <= in_flight + (PW+1)'(req_fire) - (PW+1)'(rsp_fill);
    end
  end
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (in_flight != '0 || discard_cnt != '0));
  assert property (@(posedge clk) disable iff (!rst_n)
    bus.id_valid && !bus.id_ready |=> bus.id_valid || flush);
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch queue, stalls, flush discards and reset
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n, flush, pc_en, rsp_en;
  logic [31:0] pc_current, target;
  logic [31:0] pend [$];
  int n_cmp = 0;
  int n_err = 0;
  instr_fetch_if #(.XLEN(32)) bus();
  instr_fetch_unit #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_current(pc_current), .pc_en(pc_en), .flush(flush), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // PC register model: advance by 4, or load target on flush
  task automatic tick();
    logic en, fl;
    en = pc_en;
    fl = flush;
    @(posedge clk);
    #2;
    if (en) pc_current = fl ? target : pc_current + 32'd4;
    #1;
  endtask
  task automatic expect_id(input logic [31:0] p, input logic [31:0] w);
    for (int i = 0; i < 12; i++) begin
      if (bus.id_valid) begin
        check("id_pc", bus.id_pc, p);
        check("id_instr", bus.id_instr, w);
        tick();
        return;
      end
      tick();
    end
    check("id_timeout", 32'd0, 32'd1);
  endtask
  task automatic drain();
    bus.imem_req_ready = 1'b0;
    bus.id_ready = 1'b1;
    rsp_en = 1'b1;
    #1;
    repeat (5) tick();
    check("drain_occ", 32'(dut.occ), 32'd0);
  endtask
  // one-cycle in-order memory returning {addr[15:0], 16'hC0DE}
  initial begin
    logic f;
    logic [31:0] a, r;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      f = rst_n && bus.imem_req_valid && bus.imem_req_ready;
      a = bus.imem_req_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend.delete();
        bus.imem_rsp_valid = 1'b0;
      end else begin
        if (f) pend.push_back(a);
        if (rsp_en && pend.size() > 0) begin
          r = pend.pop_front();
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data = {r[15:0], 16'hC0DE};
        end else bus.imem_rsp_valid = 1'b0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    target = '0;
    rsp_en = 1'b1;
    pc_current = 32'h44;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_addr", bus.imem_req_addr, 32'h0);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    pc_current = 32'h0;
    #1;
    check("s_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("s_pc_en", 32'(pc_en), 32'd1);
    check("s_addr", bus.imem_req_addr, 32'h0);
    tick();
    check("s_lat_c1", 32'(bus.id_valid), 32'd0);
    tick();
    check("s_lat_c2", 32'(bus.id_valid), 32'd1);
    expect_id(32'h0, 32'h0000C0DE);
    expect_id(32'h4, 32'h0004C0DE);
    expect_id(32'h8, 32'h0008C0DE);
    drain();
    pc_current = 32'h10;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rr_pc_en", 32'(pc_en), 32'd0);
      check("rr_addr", bus.imem_req_addr, 32'h10);
      tick();
    end
    check("rr_occ", 32'(dut.occ), 32'd0);
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b0;
    #1;
    tick();
    tick();
    check("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("full_pc_en", 32'(pc_en), 32'd0);
    check("full_id_valid", 32'(bus.id_valid), 32'd1);
    check("full_id_pc", bus.id_pc, 32'h10);
    tick();
    check("full_hold_pc", bus.id_pc, 32'h10);
    check("full_hold_addr", bus.imem_req_addr, 32'h18);
    bus.id_ready = 1'b1;
    #1;
    tick();
    check("resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("resume_pc_en", 32'(pc_en), 32'd1);
    check("resume_id_pc", bus.id_pc, 32'h14);
    drain();
    pc_current = 32'h20;
    rsp_en = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    tick();
    tick();
    check("fl_inflight", 32'(dut.in_flight), 32'd2);
    flush = 1'b1;
    target = 32'h100;
    #1;
    check("fl_pc_en", 32'(pc_en), 32'd1);
    check("fl_id_valid", 32'(bus.id_valid), 32'd0);
    check("fl_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    flush = 1'b0;
    rsp_en = 1'b1;
    #1;
    check("fl_occ", 32'(dut.occ), 32'd0);
    check("fl_disc0", 32'(dut.discard_cnt), 32'd2);
    tick();
    check("fl_disc1", 32'(dut.discard_cnt), 32'd2);
    tick();
    check("fl_disc2", 32'(dut.discard_cnt), 32'd1);
    tick();
    check("fl_disc3", 32'(dut.discard_cnt), 32'd0);
    expect_id(32'h100, 32'h0100C0DE);
    expect_id(32'h104, 32'h0104C0DE);
    drain();
    pc_current = 32'h200;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b0;
    #1;
    tick();
    tick();
    check("co_id_pc", bus.id_pc, 32'h200);
    check("co_rsp", 32'(bus.imem_rsp_valid), 32'd1);
    flush = 1'b1;
    target = 32'h300;
    bus.id_ready = 1'b1;
    #1;
    check("co_id_valid", 32'(bus.id_valid), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("co_disc", 32'(dut.discard_cnt), 32'd0);
    check("co_occ", 32'(dut.occ), 32'd0);
    expect_id(32'h300, 32'h0300C0DE);
    drain();
    pc_current = 32'h400;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b0;
    #1;
    tick();
    tick();
    tick();
    check("mr_occ", 32'(dut.occ), 32'd2);
    check("mr_id_pc", bus.id_pc, 32'h400);
    rst_n = 1'b0;
    #1;
    check("mr_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("mr_pc_en", 32'(pc_en), 32'd0);
    check("mr_id_valid", 32'(bus.id_valid), 32'd0);
    check("mr_id_pc0", bus.id_pc, 32'h0);
    check("mr_id_instr0", bus.id_instr, 32'h0);
    check("mr_addr", bus.imem_req_addr, 32'h0);
    tick();
    pc_current = 32'h500;
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    #1;
    expect_id(32'h500, 32'h0500C0DE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
